// File: rtl/svga_pkg.sv
// Shared SVGA timing definitions: the vertical phase encoding, the default
// 800x600 vertical constants and the pixel/line position width.
package svga_pkg;

  localparam int POS_W        = 10;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_e;

  // Phase order within a frame; front porch closes the loop back to sync.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_SYNC: next_phase = PH_BP;
      PH_BP:   next_phase = PH_ACT;
      PH_ACT:  next_phase = PH_FP;
      default: next_phase = PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/v_timing.sv
// Vertical timing generator. Advances one line per line_end pulse from the
// horizontal counter and produces y_pos, vsync, v_active, frame_start and an
// optional frame counter. All outputs are registered, so they change in the
// cycle after the sampled line_end and stay stable for the whole line.
// Optional feature: define V_TIMING_FRAME_CNT_EN to build the 8-bit frame
// counter; otherwise frame_cnt is tied to zero.
module v_timing
  import svga_pkg::*;
#(
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             line_end,
  output logic [POS_W-1:0] y_pos,
  output logic             vsync,
  output logic             v_active,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Offset of the first active line from the top of the frame; y_pos is the
  // absolute line minus this, wrapping modulo 2**POS_W outside the window.
  localparam logic [POS_W-1:0] Y_OFS = POS_W'(V_SYNC + V_BP);
  localparam logic [POS_W-1:0] Y_RST = POS_W'((1 << POS_W) - (V_SYNC + V_BP));

  // Refuse to build with an empty phase or a frame taller than the counters.
  if (V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_TOTAL > (1 << POS_W))
  begin : g_param_err
    $error("v_timing: every phase must be >= 1 line and V_TOTAL <= 1024");
  end

  // Last line index within each phase.
  function automatic logic [POS_W-1:0] phase_last(input phase_e ph);
    case (ph)
      PH_SYNC: phase_last = POS_W'(V_SYNC - 1);
      PH_BP:   phase_last = POS_W'(V_BP - 1);
      PH_ACT:  phase_last = POS_W'(V_ACTIVE - 1);
      default: phase_last = POS_W'(V_FP - 1);
    endcase
  endfunction

  phase_e           r_state;
  logic [POS_W-1:0] r_lcnt;
  logic [POS_W-1:0] r_vline;
  logic [POS_W-1:0] r_y_pos;
  logic             r_vsync;
  logic             r_v_active;
  logic             r_frame_start;

  phase_e           w_state_nxt;
  logic [POS_W-1:0] w_lcnt_nxt;
  logic [POS_W-1:0] w_vline_nxt;
  logic             w_frame_wrap;

  // Next phase, in-phase line count and absolute line on each line_end.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_state_nxt  = r_state;
    w_lcnt_nxt   = r_lcnt;
    w_vline_nxt  = r_vline;
    w_frame_wrap = 1'b0;
    if (line_end) begin
      if (r_lcnt == phase_last(r_state)) begin
        w_state_nxt  = next_phase(r_state);
        w_lcnt_nxt   = '0;
        w_frame_wrap = (r_state == PH_FP);
      end else begin
        w_lcnt_nxt = r_lcnt + 1'b1;
      end
      // The absolute line wraps exactly when the frame closes.
      w_vline_nxt = w_frame_wrap ? '0 : r_vline + 1'b1;
    end
  end

  // Phase state and line counters.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state <= PH_SYNC;
      r_lcnt  <= '0;
      r_vline <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lcnt  <= w_lcnt_nxt;
      r_vline <= w_vline_nxt;
    end
  end

  // Output registers, decoded from the next-state values so they line up
  // with the counters in the same cycle.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_y_pos       <= Y_RST;
      r_vsync       <= VSYNC_POL;
      r_v_active    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_y_pos       <= w_vline_nxt - Y_OFS;
      r_vsync       <= (w_state_nxt == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      r_v_active    <= (w_state_nxt == PH_ACT);
      r_frame_start <= w_frame_wrap;
    end
  end

`ifdef V_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  // Frame counter, stepping on the same edge that raises frame_start.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 8'd0;
`endif

  assign y_pos       = r_y_pos;
  assign vsync       = r_vsync;
  assign v_active    = r_v_active;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_v_timing.sv
// Bench for v_timing: a default 800x600 instance and a tiny-frame instance
// (1/1/2/1 lines, inverted sync) share one line_end stream. A frame-level
// model derives every output from the number of lines seen since reset and
// is compared on each falling clock edge; literal checks pin key points.
module tb_v_timing;

  localparam int CLK_HALF = 5;
`ifdef V_TIMING_FRAME_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       line_end = 1'b0;

  logic [9:0] y_pos_d, y_pos_s;
  logic       vsync_d, vsync_s;
  logic       v_active_d, v_active_s;
  logic       frame_start_d, frame_start_s;
  logic [7:0] frame_cnt_d, frame_cnt_s;

  int n_vec = 0;
  int n_bad = 0;

  v_timing u_dut_def (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .line_end    (line_end),
    .y_pos       (y_pos_d),
    .vsync       (vsync_d),
    .v_active    (v_active_d),
    .frame_start (frame_start_d),
    .frame_cnt   (frame_cnt_d)
  );

  v_timing #(
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1), .VSYNC_POL(1'b0)
  ) u_dut_sml (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .line_end    (line_end),
    .y_pos       (y_pos_s),
    .vsync       (vsync_s),
    .v_active    (v_active_s),
    .frame_start (frame_start_s),
    .frame_cnt   (frame_cnt_s)
  );

  always #CLK_HALF sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {
    int y;
    int vs;
    int act;
    int cnt;
  } exp_t;

  // Everything follows from the line count since reset: position in frame,
  // frames completed, and the phase boundaries as plain line ranges.
  function automatic exp_t model(input int lines, input int s, input int b,
                                 input int a, input int f, input int pol);
    exp_t e;
    int   tot = s + b + a + f;
    int   v   = lines % tot;
    e.y   = (v - (s + b) + 1024) % 1024;
    e.vs  = (v < s) ? pol : 1 - pol;
    e.act = (v >= s + b && v < s + b + a) ? 1 : 0;
    e.cnt = CNT_ON ? (lines / tot) % 256 : 0;
    return e;
  endfunction

  int lines = 0;
  int fs_d_exp = 0;
  int fs_s_exp = 0;

  // Count accepted line_end edges; a frame-start is expected in the cycle
  // after the edge that completes a whole frame.
  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      lines    <= 0;
      fs_d_exp <= 0;
      fs_s_exp <= 0;
    end else if (line_end) begin
      lines    <= lines + 1;
      fs_d_exp <= ((lines + 1) % 628 == 0) ? 1 : 0;
      fs_s_exp <= ((lines + 1) % 5 == 0) ? 1 : 0;
    end else begin
      fs_d_exp <= 0;
      fs_s_exp <= 0;
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge sys_clk) begin
    exp_t ed;
    exp_t es;
    ed = model(lines, 4, 23, 600, 1, 1);
    es = model(lines, 1, 1, 2, 1, 0);
    check("def.y_pos",       int'(y_pos_d),       ed.y);
    check("def.vsync",       int'(vsync_d),       ed.vs);
    check("def.v_active",    int'(v_active_d),    ed.act);
    check("def.frame_start", int'(frame_start_d), fs_d_exp);
    check("def.frame_cnt",   int'(frame_cnt_d),   ed.cnt);
    check("sml.y_pos",       int'(y_pos_s),       es.y);
    check("sml.vsync",       int'(vsync_s),       es.vs);
    check("sml.v_active",    int'(v_active_s),    es.act);
    check("sml.frame_start", int'(frame_start_s), fs_s_exp);
    check("sml.frame_cnt",   int'(frame_cnt_s),   es.cnt);
  end

  // ---------------- stimulus ----------------
  // Each task starts and ends 2 time units after a rising edge.
  task automatic pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      line_end = 1'b1;
      @(posedge sys_clk); #2;
      line_end = 1'b0;
      for (int j = 1; j < gap; j++) begin
        @(posedge sys_clk); #2;
      end
    end
  endtask

  task automatic hold(input int n);
    line_end = 1'b1;
    repeat (n) begin
      @(posedge sys_clk); #2;
    end
    line_end = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #2;
    check("rst.def.y_pos",    int'(y_pos_d), 997);
    check("rst.def.vsync",    int'(vsync_d), 1);
    check("rst.def.v_active", int'(v_active_d), 0);
    check("rst.sml.y_pos",    int'(y_pos_s), 1022);
    check("rst.sml.vsync",    int'(vsync_s), 0);
    reset = 1'b0;

    // Sync phase: vsync drops right after the 4th line.
    pulses(3, 2);
    check("sync.vsync@3", int'(vsync_d), 1);
    pulses(1, 1);
    check("sync.vsync@4", int'(vsync_d), 0);
    check("sync.v_active@4", int'(v_active_d), 0);

    // Active window.
    pulses(22, 2);
    check("act.v_active@26", int'(v_active_d), 0);
    pulses(1, 1);
    check("act.v_active@27", int'(v_active_d), 1);
    check("act.y_pos@27",    int'(y_pos_d), 0);
    pulses(599, 2);
    check("act.y_pos@626",   int'(y_pos_d), 599);
    check("act.v_active@626", int'(v_active_d), 1);
    pulses(1, 1);
    check("fp.v_active@627", int'(v_active_d), 0);
    check("fp.vsync@627",    int'(vsync_d), 0);

    // Frame wrap and one-cycle frame_start.
    pulses(1, 1);
    check("wrap.vsync",       int'(vsync_d), 1);
    check("wrap.y_pos",       int'(y_pos_d), 997);
    check("wrap.frame_start", int'(frame_start_d), 1);
    check("wrap.frame_cnt",   int'(frame_cnt_d), CNT_ON ? 1 : 0);
    @(posedge sys_clk); #2;
    check("wrap.frame_start_off", int'(frame_start_d), 0);

    // Widely spaced pulses follow the same line sequence.
    pulses(5, 1064);
    check("space.y_pos@5", int'(y_pos_d), 1002);
    check("space.vsync@5", int'(vsync_d), 0);

    // Reset in the middle of the active region.
    pulses(295, 2);
    check("mid.y_pos@300", int'(y_pos_d), 273);
    check("mid.v_active@300", int'(v_active_d), 1);
    #1 reset = 1'b1;
    #1;
    check("mid.rst.y_pos",    int'(y_pos_d), 997);
    check("mid.rst.vsync",    int'(vsync_d), 1);
    check("mid.rst.v_active", int'(v_active_d), 0);
    check("mid.rst.frame_cnt", int'(frame_cnt_d), 0);
    @(posedge sys_clk); #2;
    reset = 1'b0;
    pulses(3, 2);
    check("mid.vsync@3", int'(vsync_d), 1);
    pulses(1, 2);
    check("mid.vsync@4", int'(vsync_d), 0);

    // line_end held for 3 cycles advances 3 lines.
    check("hold.y_pos@4", int'(y_pos_d), 1001);
    hold(3);
    check("hold.y_pos@7", int'(y_pos_d), 1004);

    // 256 small frames wrap the small instance's frame counter.
    reset = 1'b1;
    @(posedge sys_clk); #2;
    reset = 1'b0;
    hold(5);
    check("cnt.sml.frame_start@1", int'(frame_start_s), 1);
    check("cnt.sml.frame_cnt@1",   int'(frame_cnt_s), CNT_ON ? 1 : 0);
    hold(1274);
    check("cnt.sml.frame_cnt@255", int'(frame_cnt_s), CNT_ON ? 255 : 0);
    hold(1);
    check("cnt.sml.frame_cnt@256", int'(frame_cnt_s), 0);
    check("cnt.sml.vsync@256",     int'(vsync_s), 0);

    repeat (3) @(posedge sys_clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
